// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings driven on the unit's op input
//   - FSM state encoding used by the top level
//   - default operand width and small op-decode helpers
package mult_div_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    // op[1] selects divide, op[0] selects the unsigned variant
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_core.sv
// Iterative datapath for MULT/MULTU/DIV/DIVU.
//   clk, reset    : clock, asynchronous active-low reset
//   i_load        : capture operands/op (operation accepted this cycle)
//   i_step        : perform one iteration (one bit per cycle)
//   i_op          : op encoding, sampled with i_load
//   i_a, i_b      : multiplicand/dividend, multiplier/divisor
//   o_hi, o_lo    : sign-corrected result, valid after the last step
//   o_div_zero    : latched op was a divide with a zero divisor
module mult_div_core
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_zero
);

    logic               r_is_div;
    logic               r_signed;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_b_zero;
    // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]   r_opnd;
    // multiply: {partial product, remaining multiplier bits}
    // divide:   low half holds dividend bits shifting out / quotient shifting in
    logic [2*WIDTH-1:0] r_acc;
    // The remainder is always below the divisor, so WIDTH bits suffice in the
    // register; the extra bit only exists in the shifted/subtracted value.
    logic [WIDTH-1:0]   r_rem;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_q_bit;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_mag_a = (op_is_signed(i_op) && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b = (op_is_signed(i_op) && i_b[WIDTH-1]) ? -i_b : i_b;

    // shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // restoring division: a set MSB of the difference means "went negative"
    assign w_rem_sh = {r_rem, r_acc[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opnd};
    assign w_q_bit  = ~w_diff[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
        end else if (i_load) begin
            r_is_div <= op_is_div(i_op);
            r_signed <= op_is_signed(i_op);
            r_sign_a <= i_a[WIDTH-1];
            r_sign_b <= i_b[WIDTH-1];
            r_b_zero <= (i_b == '0);
            r_opnd   <= op_is_div(i_op) ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, (op_is_div(i_op) ? w_mag_a : w_mag_b)};
            r_rem    <= '0;
        end else if (i_step) begin
            if (r_is_div) begin
                r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_q_bit};
                r_rem            <= w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            end else begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
        end
    end

    assign w_neg      = r_signed & (r_sign_a ^ r_sign_b);
    assign w_prod_fix = w_neg ? -r_acc : r_acc;
    assign w_quo_fix  = w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = (r_signed && r_sign_a) ? -r_rem : r_rem;

    // With a zero divisor every trial subtraction succeeds, so the remainder
    // ends up as the dividend magnitude and the sign fix restores the original
    // dividend; only the quotient needs forcing to all-ones.
    assign o_hi       = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign o_lo       = r_is_div ? (r_b_zero ? '1 : w_quo_fix) : w_prod_fix[WIDTH-1:0];
    assign o_div_zero = r_is_div & r_b_zero;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style multiply/divide unit with HI/LO registers.
//   clk, reset          : clock, asynchronous active-low reset
//   start, op           : launch MULT/MULTU/DIV/DIVU (accepted only in IDLE)
//   rs_data, rt_data    : operands; rs_data is also the MTHI/MTLO data
//   hi_we, lo_we        : MTHI/MTLO write enables (IDLE only, start wins)
//   busy                : operation in flight
//   done                : one-cycle pulse when HI/LO take a result
//   div_by_zero         : pulses with done for a divide by zero
//   hi, lo              : HI/LO registers
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic             w_core_dz;

    mult_div_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_op       (op),
        .i_a        (rs_data),
        .i_b        (rt_data),
        .o_hi       (w_core_hi),
        .o_lo       (w_core_lo),
        .o_div_zero (w_core_dz)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = (r_cnt == CNT_LAST);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) w_state_nxt = FIX;
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            // flags are registered from next-state so they line up with the state
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (r_state == FIX);
            r_dz    <= (r_state == FIX) && w_core_dz;

            if (w_load || (w_step && w_last)) r_cnt <= '0;
            else if (w_step)                  r_cnt <= r_cnt + 1'b1;

            if (r_state == FIX) begin
                r_hi <= w_core_hi;
                r_lo <= w_core_lo;
            end else if (r_state == IDLE && !start) begin
                if (hi_we) r_hi <= rs_data;
                if (lo_we) r_lo <= rs_data;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // caller sits #1 after a rising edge; returns #1 after the accepting edge
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // counts edges until done is seen; -1 on timeout
    task automatic wait_done(output int lat);
        bit found;
        found = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(posedge clk); #1;
            if (done) begin
                found = 1'b1;
                lat   = i;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  seen_done;

        vecs[0]  = '{"mult_neg",     OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{"mult_minmin",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{"multu_2p32",   OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0};
        vecs[4]  = '{"multu_zero",   OP_MULTU, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0};
        vecs[5]  = '{"div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{"div_7_m2",     OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{"div_m7_m2",    OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
        vecs[8]  = '{"div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[9]  = '{"divu_100_7",   OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[10] = '{"divu_max_1",   OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{"divu_by_zero", OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        vecs[12] = '{"div_by_zero",  OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz",   64'(div_by_zero), 64'd0);
        check("rst_hi",   64'(hi), 64'd0);
        check("rst_lo",   64'(lo), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // table-driven ops
        foreach (vecs[i]) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_busy"}, 64'(busy), 64'd1);
            wait_done(lat);
            check({vecs[i].name, "_lat"},  64'(lat), 64'(W + 1));
            check({vecs[i].name, "_hi"},   64'(hi), 64'(vecs[i].hi));
            check({vecs[i].name, "_lo"},   64'(lo), 64'(vecs[i].lo));
            check({vecs[i].name, "_dz"},   64'(div_by_zero), 64'(vecs[i].dz));
            check({vecs[i].name, "_idle"}, 64'(busy), 64'd0);
            @(posedge clk); #1;
            check({vecs[i].name, "_done1"}, 64'(done), 64'd0);
            check({vecs[i].name, "_dz1"},   64'(div_by_zero), 64'd0);
        end

        // MTLO alone
        lo_we = 1'b1; rs_data = 32'h12345678;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h12345678);

        // MTHI and MTLO together
        hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'h55AA55AA;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mtboth_hi", 64'(hi), 64'h55AA55AA);
        check("mtboth_lo", 64'(lo), 64'h55AA55AA);

        // start and MTLO in the same cycle: start wins
        lo_we = 1'b1;
        launch(OP_MULTU, 32'd2, 32'd3);
        lo_we = 1'b0;
        check("startwin_lo_kept", 64'(lo), 64'h55AA55AA);
        check("startwin_busy",    64'(busy), 64'd1);
        wait_done(lat);
        check("startwin_lat", 64'(lat), 64'(W + 1));
        check("startwin_hi",  64'(hi), 64'd0);
        check("startwin_lo",  64'(lo), 64'd6);

        // MTHI while busy and a second start mid-run are both ignored
        hi_we = 1'b1; rs_data = 32'h0A0A0A0A;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'h0A0A0A0A);
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        hi_we = 1'b1; rs_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("busy_mthi_hi", 64'(hi), 64'h0A0A0A0A);
        check("busy_mthi_busy", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = OP_MULT; rs_data = 32'd5; rt_data = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check("restart_lat", 64'(lat), 64'(W + 1 - 10));
        check("restart_hi",  64'(hi), 64'd2);
        check("restart_lo",  64'(lo), 64'd14);
        @(posedge clk); #1;
        check("restart_idle", 64'(busy), 64'd0);

        // back-to-back: start during the done cycle is accepted
        launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done(lat);
        check("b2b_a_lat", 64'(lat), 64'(W + 1));
        check("b2b_a_hi",  64'(hi), 64'hFFFFFFFF);
        check("b2b_a_lo",  64'(lo), 64'hFFFFFFEB);
        launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
        check("b2b_b_busy", 64'(busy), 64'd1);
        check("b2b_b_done", 64'(done), 64'd0);
        wait_done(lat);
        check("b2b_b_lat", 64'(lat), 64'(W + 1));
        check("b2b_b_hi",  64'(hi), 64'hFFFFFFFF);
        check("b2b_b_lo",  64'(lo), 64'hFFFFFFFD);

        // reset mid-operation aborts with no done
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi",   64'(hi), 64'd0);
        check("midrst_lo",   64'(lo), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("midrst_no_done", 64'(seen_done), 64'd0);
        check("midrst_idle",    64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
